// File: rtl/rvvi_frame_packer.sv
// Packs RVVI trace records into Ethernet-style frames on an AXI write-data stream.
// Optional idle flush of partial frames is enabled by defining RVVI_FRAME_TIMEOUT_EN.
module rvvi_frame_packer #(
  parameter int RVVI_WIDTH     = 392,
  parameter int BUS_WIDTH      = 32,
  parameter int MAX_INSTRS     = 8,
  parameter int INIT_TIME_OUT  = 4,
  parameter int FLUSH_TIME_OUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RVVI_WIDTH-1:0]  rvvi,
  input  logic                   valid,
  output logic                   ready,
  output logic [BUS_WIDTH-1:0]   RvviAxiWdata,
  output logic [BUS_WIDTH/8-1:0] RvviAxiWstrb,
  output logic                   RvviAxiWlast,
  output logic                   RvviAxiWvalid,
  input  logic                   RvviAxiWready,
  input  logic [47:0]            SrcMac,
  input  logic [47:0]            DstMac,
  input  logic [15:0]            EthType,
  input  logic [15:0]            AckType,
  input  logic [31:0]            InnerPktDelay,
  output logic [63:0]            FrameCount
);

  localparam int RW   = (RVVI_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int HW   = 256 / BUS_WIDTH;
  localparam int PADW = RW * BUS_WIDTH;
  localparam int CW   = $clog2(MAX_INSTRS + 1);
  localparam int IW   = (MAX_INSTRS > 1) ? $clog2(MAX_INSTRS) : 1;
  localparam int SW   = (RW > 1) ? $clog2(RW) : 1;
  localparam int HIW  = (HW > 1) ? $clog2(HW) : 1;

  localparam logic [CW-1:0]  MAX_C     = CW'(MAX_INSTRS);
  localparam logic [SW-1:0]  RW_LAST   = SW'(RW - 1);
  localparam logic [HIW-1:0] HW_LAST   = HIW'(HW - 1);
  localparam logic [31:0]    INIT_C    = 32'(INIT_TIME_OUT);

  typedef enum logic [2:0] {RST, INIT, COLLECT, HDR, DATA, DELAY} state_t;

  state_t                  r_state;
  logic [31:0]             r_cycle;
  logic [CW-1:0]           r_rec_count;
  logic [63:0]             r_frame_count;
  logic [RVVI_WIDTH-1:0]   r_fifo [MAX_INSTRS];
  logic [255:0]            r_hdr;
  logic [HIW-1:0]          r_hdr_idx;
  logic [IW-1:0]           r_rec_idx;
  logic [SW-1:0]           r_sub_idx;

  logic                    w_accept;
  logic [CW-1:0]           w_count_next;
  logic                    w_flush;
  logic                    w_collect_done;
  logic                    w_xfer;
  logic                    w_rec_last;
  logic                    w_last;
  logic [HW-1:0][BUS_WIDTH-1:0] w_hdr_words;
  logic [RW-1:0][BUS_WIDTH-1:0] w_rec_words;

  assign ready          = (r_state == COLLECT) && (r_rec_count < MAX_C);
  assign w_accept       = valid & ready;
  assign w_count_next   = r_rec_count + CW'(w_accept);
  assign w_collect_done = (r_state == COLLECT) && ((w_count_next == MAX_C) || w_flush);
  assign w_xfer         = RvviAxiWvalid & RvviAxiWready;

`ifdef RVVI_FRAME_TIMEOUT_EN
  localparam logic [31:0] FLUSH_C = 32'(FLUSH_TIME_OUT);
  logic [31:0] r_idle;

  assign w_flush = (r_idle == FLUSH_C) && (w_count_next != '0);

  // Idle counter only runs while a partial frame is waiting for more records.
  always_ff @(posedge clk) begin
    if (reset || (r_state != COLLECT) || w_accept || w_flush)
      r_idle <= '0;
    else if (r_rec_count != '0)
      r_idle <= r_idle + 32'd1;
  end
`else
  assign w_flush = 1'b0;
`endif

  assign w_hdr_words = r_hdr;
  assign w_rec_words = PADW'(r_fifo[r_rec_idx]);
  assign w_rec_last  = ((CW'(r_rec_idx) + CW'(1)) == r_rec_count);
  assign w_last      = (r_state == DATA) && w_rec_last && (r_sub_idx == RW_LAST);

  // Output words come straight from registered pointers, so they hold while stalled.
  assign RvviAxiWvalid = (r_state == HDR) || (r_state == DATA);
  assign RvviAxiWlast  = w_last;
  assign RvviAxiWstrb  = '1;
  assign FrameCount    = r_frame_count;

  always_comb begin
    RvviAxiWdata = '0;
    if (r_state == HDR)
      RvviAxiWdata = w_hdr_words[r_hdr_idx];
    else if (r_state == DATA)
      RvviAxiWdata = w_rec_words[r_sub_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RST;
      r_cycle       <= '0;
      r_rec_count   <= '0;
      r_frame_count <= '0;
      r_hdr_idx     <= '0;
      r_rec_idx     <= '0;
      r_sub_idx     <= '0;
    end else begin
      case (r_state)
        RST: begin
          r_cycle <= 32'd1;
          r_state <= INIT;
        end
        INIT: begin
          if (r_cycle >= INIT_C)
            r_state <= COLLECT;
          else
            r_cycle <= r_cycle + 32'd1;
        end
        COLLECT: begin
          r_rec_count <= w_count_next;
          if (w_collect_done) begin
            r_hdr_idx <= '0;
            r_state   <= HDR;
          end
        end
        HDR: begin
          if (w_xfer) begin
            if (r_hdr_idx == HW_LAST) begin
              r_rec_idx <= '0;
              r_sub_idx <= '0;
              r_state   <= DATA;
            end else begin
              r_hdr_idx <= r_hdr_idx + HIW'(1);
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            if (w_last) begin
              r_frame_count <= r_frame_count + 64'd1;
              r_rec_count   <= '0;
              r_cycle       <= '0;
              r_state       <= DELAY;
            end else if (r_sub_idx == RW_LAST) begin
              r_sub_idx <= '0;
              r_rec_idx <= r_rec_idx + IW'(1);
            end else begin
              r_sub_idx <= r_sub_idx + SW'(1);
            end
          end
        end
        DELAY: begin
          if (r_cycle >= InnerPktDelay)
            r_state <= COLLECT;
          else
            r_cycle <= r_cycle + 32'd1;
        end
        default: r_state <= RST;
      endcase
    end
  end

  // Record storage and header snapshot carry no reset; RecCount alone marks validity.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_fifo[r_rec_count[IW-1:0]] <= rvvi;
    if (w_collect_done)
      r_hdr <= {48'b0, 16'(w_count_next), r_frame_count, AckType, EthType, DstMac, SrcMac};
  end

endmodule

// File: tb/tb_rvvi_frame_packer.sv
// Scoreboard bench for rvvi_frame_packer: expected AXI words are queued, a monitor pops and compares.
module tb_rvvi_frame_packer;

  localparam int RVW = 100;
  localparam int BW  = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [RVW-1:0]  rvvi = '0;
  logic            valid = 1'b0;
  logic            ready;
  logic [BW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready = 1'b1;
  logic [47:0]     src = 48'h0A1B_2C3D_4E5F;
  logic [47:0]     dst = 48'h1122_3344_5566;
  logic [15:0]     eth = 16'h88B5;
  logic [15:0]     ack = 16'h0001;
  logic [31:0]     ipd = 32'd3;
  logic [63:0]     fcount;

  rvvi_frame_packer #(
    .RVVI_WIDTH(RVW), .BUS_WIDTH(BW), .MAX_INSTRS(4),
    .INIT_TIME_OUT(4), .FLUSH_TIME_OUT(10)
  ) dut (
    .clk(clk), .reset(reset), .rvvi(rvvi), .valid(valid), .ready(ready),
    .RvviAxiWdata(wdata), .RvviAxiWstrb(wstrb), .RvviAxiWlast(wlast),
    .RvviAxiWvalid(wvalid), .RvviAxiWready(wready),
    .SrcMac(src), .DstMac(dst), .EthType(eth), .AckType(ack),
    .InnerPktDelay(ipd), .FrameCount(fcount)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW:0] exp_q[$];
  int          exp_len_q[$];
  int          words_in_frame = 0;
  int          frames_seen = 0;
  int          wr_mode = 0;
  logic        prev_stall = 1'b0;
  logic [BW:0] prev_out = '0;
  logic [BW:0] mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RVW-1:0] rec_val(input int i);
    logic [3:0] t;
    t = 4'(i);
    return {4'hC ^ t, 32'h1234_5600 + 32'(i), 32'h89AB_CD00 + 32'(i), 32'h0F0F_0000 + 32'(i)};
  endfunction

  // Expected frame: 8 header words then 4 zero-padded words per record, LSB first.
  task automatic push_frame(input int first_rec, input int n, input logic [63:0] fc);
    logic [255:0] hdr;
    logic [127:0] pad;
    hdr = {48'b0, 16'(n), fc, ack, eth, dst, src};
    for (int h = 0; h < 8; h++) exp_q.push_back({1'b0, hdr[h*32 +: 32]});
    for (int r = 0; r < n; r++) begin
      pad = {28'b0, rec_val(first_rec + r)};
      for (int s = 0; s < 4; s++)
        exp_q.push_back({(r == n - 1) && (s == 3), pad[s*32 +: 32]});
    end
    exp_len_q.push_back(8 + 4 * n);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    wready = (wr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (reset) begin
      words_in_frame = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 128'({wvalid, wlast, wdata}), 128'({1'b1, prev_out}));
      prev_stall = wvalid & ~wready;
      prev_out = {wlast, wdata};
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("axi_word", 128'({wlast, wdata}), 128'(mon_e));
        end
        words_in_frame++;
        if (wlast) begin
          check("wstrb", 128'(wstrb), 128'(4'hF));
          if (exp_len_q.size() > 0)
            check("frame_len", 128'(words_in_frame), 128'(exp_len_q.pop_front()));
          frames_seen++;
          words_in_frame = 0;
        end
      end
    end
  end

  task automatic send_rec(input int i);
    int   c;
    logic r;
    rvvi  = rec_val(i);
    valid = 1'b1;
    c = 0;
    r = 1'b0;
    while (!r && c < 200) begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      #1;
      c++;
    end
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: record %0d not accepted, required acceptance", i);
    end
  endtask

  task automatic wait_frames(input int target);
    int c;
    c = 0;
    while (frames_seen < target && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("frame_done", 128'(frames_seen >= target), 128'(1));
  endtask

  initial begin
    int   cyc;
    logic seen_wv;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_wvalid", 128'(wvalid), 128'(0));
    check("rst_wlast", 128'(wlast), 128'(0));
    check("rst_wdata", 128'(wdata), 128'(0));
    check("rst_framecount", 128'(fcount), 128'(0));

    // Frame 1: valid held across reset release, back-to-back records, Wready high.
    push_frame(0, 4, 64'd0);
    rvvi  = rec_val(0);
    valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    seen_wv = 1'b0;
    while (!ready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wvalid) seen_wv = 1'b1;
    end
    check("init_ready_latency", 128'(cyc), 128'(5));
    check("init_no_wvalid", 128'(seen_wv), 128'(0));
    for (int i = 0; i < 4; i++) send_rec(i);
    valid = 1'b0;
    wait_frames(1);
    check("framecount_1", 128'(fcount), 128'(1));

    cyc = 0;
    while (!ready && cyc < 50) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    check("delay_ready_low", 128'((cyc >= 3) && (cyc < 50)), 128'(1));

    // Frame 2: random Wready stalls, header FrameCount 1.
    push_frame(4, 4, 64'd1);
    wr_mode = 1;
    for (int i = 4; i < 8; i++) send_rec(i);
    valid = 1'b0;
    ipd = 32'd0;
    wait_frames(2);
    wr_mode = 0;
    check("framecount_2", 128'(fcount), 128'(2));

    // Frame 3: single record then idle.
`ifdef RVVI_FRAME_TIMEOUT_EN
    push_frame(8, 1, 64'd2);
    send_rec(8);
    valid = 1'b0;
    cyc = 0;
    while (!wvalid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("flush_latency", 128'((cyc >= 10) && (cyc <= 11)), 128'(1));
    wait_frames(3);
`else
    send_rec(8);
    valid = 1'b0;
    seen_wv = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (wvalid) seen_wv = 1'b1;
    end
    check("no_partial_flush", 128'(seen_wv), 128'(0));
    push_frame(8, 4, 64'd2);
    for (int i = 9; i < 12; i++) send_rec(i);
    valid = 1'b0;
    wait_frames(3);
`endif
    check("framecount_3", 128'(fcount), 128'(3));

    // Frame 4 aborted by reset at data word 10.
    push_frame(12, 4, 64'd3);
    for (int i = 12; i < 16; i++) send_rec(i);
    valid = 1'b0;
    cyc = 0;
    while (words_in_frame < 18 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reached_data_word10", 128'(words_in_frame), 128'(18));
    reset = 1'b1;
    exp_q.delete();
    exp_len_q.delete();
    @(posedge clk);
    #1;
    check("abort_wvalid", 128'(wvalid), 128'(0));
    check("abort_ready", 128'(ready), 128'(0));
    check("abort_framecount", 128'(fcount), 128'(0));
    repeat (2) @(posedge clk);
    push_frame(16, 4, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 16; i < 20; i++) send_rec(i);
    valid = 1'b0;
    wait_frames(4);
    check("framecount_after_reset", 128'(fcount), 128'(1));
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvvi_frame_packer.md
RVVI_FRAME_PACKER -- requirements
Module: rvvi_frame_packer

Interface
REQ-001 SHALL have parameter RVVI_WIDTH, default 392: width in bits of one RVVI record.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: AXI write data width; legal values 32 and 64.
REQ-003 SHALL have parameter MAX_INSTRS, default 8: maximum number of records per frame.
REQ-004 SHALL have parameter INIT_TIME_OUT, default 4: number of post-reset PHY settle cycles.
REQ-005 SHALL have parameter FLUSH_TIME_OUT, default 64: number of idle cycles before a partial frame is flushed.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports rvvi (input, RVVI_WIDTH), valid (input, 1) and ready (output, 1): the record input handshake.
REQ-009 SHALL have ports RvviAxiWdata (output, BUS_WIDTH), RvviAxiWstrb (output, BUS_WIDTH/8), RvviAxiWlast (output, 1), RvviAxiWvalid (output, 1) and RvviAxiWready (input, 1).
REQ-010 SHALL have ports SrcMac and DstMac (inputs, 48 bits each), EthType and AckType (inputs, 16 bits each), and InnerPktDelay (input, 32 bits): the inter-frame gap in cycles.
REQ-011 SHALL have port FrameCount, output, 64 bits: the number of frames completed since reset.

Function
REQ-012 SHALL implement the states RST, INIT, COLLECT, HDR, DATA and DELAY.
REQ-013 SHALL go RST->INIT unconditionally, and INIT->COLLECT once the cycle counter equals INIT_TIME_OUT.
REQ-014 SHALL buffer accepted records in a FIFO of depth MAX_INSTRS; a record is accepted when valid&ready.
REQ-015 SHALL drive ready = (state==COLLECT) & (RecCount<MAX_INSTRS).
REQ-016 SHALL go COLLECT->HDR in the cycle after RecCount reaches MAX_INSTRS, including when the final record is accepted in that same cycle.
REQ-017 SHALL build a header of 256 bits, packed LSB-first as {48'b0, RecCount[15:0], FrameCount, AckType, EthType, DstMac, SrcMac}.
REQ-018 SHALL send the header as 256/BUS_WIDTH words, word 0 = bits[BUS_WIDTH-1:0].
REQ-019 SHALL pad each record with zeros to RW = ceil(RVVI_WIDTH/BUS_WIDTH) words and send those words LSB-first.
REQ-020 SHALL, in DATA, emit RecCount*RW words in FIFO order; RvviAxiWlast SHALL be asserted only on the final word.
REQ-021 SHALL assert RvviAxiWvalid only in HDR and DATA, and SHALL advance a word only on RvviAxiWvalid&RvviAxiWready.
REQ-022 SHALL hold RvviAxiWdata and RvviAxiWlast stable while RvviAxiWvalid&~RvviAxiWready.
REQ-023 SHALL drive RvviAxiWstrb as all ones.
REQ-024 SHALL, on the Wlast handshake, increment FrameCount (wrapping modulo 2^64), empty the FIFO, clear RecCount, and enter DELAY.
REQ-025 SHALL stay in DELAY until the cycle counter >= InnerPktDelay, then go to COLLECT; InnerPktDelay=0 SHALL give exactly one DELAY cycle.
REQ-026 SHALL keep RecCount 1..MAX_INSTRS at any frame start; an empty frame SHALL never be sent.

Reset
REQ-027 SHALL, on reset, set state RST, ready=0, RvviAxiWvalid=0, RvviAxiWlast=0, RvviAxiWdata=0, FrameCount=0, RecCount=0, clear the cycle and idle counters, and empty the FIFO.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame with RvviAxiWvalid low in the next cycle and discard all buffered records.

Configuration
REQ-029 SHALL, with macro RVVI_FRAME_TIMEOUT_EN defined, count an idle counter in COLLECT while RecCount>0 and no record is accepted; any acceptance SHALL clear it.
REQ-030 SHALL, with RVVI_FRAME_TIMEOUT_EN defined, go COLLECT->HDR when the idle counter equals FLUSH_TIME_OUT.
REQ-031 SHALL, without RVVI_FRAME_TIMEOUT_EN, contain no idle counter, and frames SHALL be sent only when RecCount==MAX_INSTRS.

Verification (BUS_WIDTH=32, RVVI_WIDTH=100 so RW=4, MAX_INSTRS=4, INIT_TIME_OUT=4, FLUSH_TIME_OUT=10)
REQ-032 SHALL cover: reset released, valid held high -> ready=0 through RST and 4 INIT cycles, then first acceptance; Wvalid=0 throughout.
REQ-033 SHALL cover: 4 records accepted back-to-back, Wready=1 -> 24 words (8 header, 16 data), Wlast only on word 24, header RecCount=4, header FrameCount=0, and FrameCount output=1 afterwards.
REQ-034 SHALL cover: 1 record then valid=0, macro defined -> HDR entered after 10 idle cycles and a 12-word frame with RecCount=1; macro undefined -> no frame sent.
REQ-035 SHALL cover: Wready toggled 1/0 pseudo-randomly during the frame -> Wdata/Wlast stable while stalled, and each word delivered exactly once in order.
REQ-036 SHALL cover: InnerPktDelay=3 -> ready=0 for >=3 cycles after Wlast, and the second frame's header FrameCount=1.
REQ-037 SHALL cover: reset asserted during DATA word 10 -> Wvalid=0 the next cycle, and the next frame after the INIT phase carries FrameCount=0.
